// File: rtl/lib_pkg.sv
// Shared constants and types for the data-memory / MMIO subsystem.
package lib_pkg;

    // MMIO register offsets, decoded on addr[7:0] inside the MMIO page
    localparam logic [7:0] MMIO_TXDATA = 8'h00;
    localparam logic [7:0] MMIO_STATUS = 8'h04;
    localparam logic [7:0] MMIO_CYCLE  = 8'h08;
    localparam logic [7:0] MMIO_TOHOST = 8'h0C;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fsm.sv
// 8N1 UART transmitter: takes one byte from the FIFO head when idle and
// serialises start bit, 8 data bits (LSB first) and stop bit, each CLK_DIV cycles.
module uart_tx_fsm
    import lib_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_pop,
    output logic       busy,
    output logic       uart_tx
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    uart_state_t   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_end;

    assign baud_end = (baud_q == BAUD_LAST);

    // Control registers: state, baud counter and bit counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
        end
    end

    // Shift register holds payload only, so it needs no reset
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    // Next-state, counter and line-level decode
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_pop  = 1'b0;
        busy    = (state_q != UART_IDLE);
        uart_tx = 1'b1;
        case (state_q)
            UART_IDLE: begin
                if (tx_valid) begin
                    tx_pop  = 1'b1;
                    shift_d = tx_byte;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                uart_tx = 1'b0;
                baud_d  = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = UART_DATA;
                end
            end
            UART_DATA: begin
                uart_tx = shift_q[0];
                baud_d  = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                    end
                end
            end
            UART_STOP: begin
                uart_tx = 1'b1;
                baud_d  = baud_q + 1'b1;
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = UART_IDLE;
                end
            end
            default: begin
                state_d = UART_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory subsystem on the core's dmem port: byte-enabled RAM in the low
// half of the address space, MMIO page (UART TX FIFO, cycle counter, tohost)
// in the upper half. Read data is combinational from the address.
module dmem_mmio
    import lib_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DADDR      = 16,
    parameter int RAM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DADDR-1:0] dmem_addr,
    input  logic [WIDTH-1:0] dmem_wdata,
    input  logic [3:0]       dmem_wr_en,
    output logic [WIDTH-1:0] dmem_rdata,
    output logic             uart_tx,
    output logic             halt,
    output logic [WIDTH-1:0] halt_code
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] ram [RAM_WORDS];
    logic [AW-1:0]    word_idx;
    logic             is_mmio;
    logic             any_wr;
    logic [7:0]       offset;
    logic             wr_txdata, wr_cycle, wr_tohost;
    logic             addr_unused;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             fifo_full, fifo_empty, push, pop, busy;

    logic [31:0]      cycle_q;

    assign word_idx    = dmem_addr[AW+1:2];
    assign is_mmio     = dmem_addr[DADDR-1];
    assign offset      = dmem_addr[7:0];
    assign any_wr      = |dmem_wr_en;
    assign wr_txdata   = is_mmio && any_wr && (offset == MMIO_TXDATA);
    assign wr_cycle    = is_mmio && any_wr && (offset == MMIO_CYCLE);
    assign wr_tohost   = is_mmio && any_wr && (offset == MMIO_TOHOST);
    // Address bits between the RAM index and the page select are don't-care
    assign addr_unused = ^dmem_addr;

    // Occupancy flags come from the pre-edge count; a push into a full FIFO is
    // dropped even if the transmitter pops in the same cycle.
    assign fifo_full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = wr_txdata && !fifo_full;

    // RAM byte-lane writes; addr[1:0] does not select lanes
    always_ff @(posedge clk) begin
        if (!is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (dmem_wr_en[i]) begin
                    ram[word_idx][8*i +: 8] <= dmem_wdata[8*i +: 8];
                end
            end
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= dmem_wdata[7:0];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Free-running cycle counter; a write clears it and wins over the increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= '0;
        end else if (wr_cycle) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
        end
    end

    // Sticky halt flag; halt_code follows every tohost write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halt      <= 1'b0;
            halt_code <= '0;
        end else if (wr_tohost) begin
            halt      <= 1'b1;
            halt_code <= dmem_wdata;
        end
    end

    uart_tx_fsm #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_byte  (fifo_mem[rd_ptr_q]),
        .tx_valid (!fifo_empty),
        .tx_pop   (pop),
        .busy     (busy),
        .uart_tx  (uart_tx)
    );

    // Read mux: RAM word or MMIO register, unmapped offsets read zero
    always_comb begin
        dmem_rdata = '0;
        if (!is_mmio) begin
            dmem_rdata = ram[word_idx];
        end else begin
            case (offset)
                MMIO_STATUS: dmem_rdata = WIDTH'({4'(count_q), 1'b0, busy, fifo_empty, fifo_full});
                MMIO_CYCLE:  dmem_rdata = WIDTH'(cycle_q);
                MMIO_TOHOST: dmem_rdata = halt_code;
                default:     dmem_rdata = '0;
            endcase
        end
    end

endmodule
